// File: rtl/halving_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : halving_pkg
//  Description : Shared types and helpers for the halving pipeline. The word
//                carries the original value, its half, its quarter and the
//                two inexactness flags between pipeline stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package halving_pkg;

    // Widest data word the pipeline carries; narrower WIDTH values are
    // zero-extended into this container.
    localparam int HALVING_W = 32;

    typedef logic [HALVING_W-1:0] halving_data_t;

    typedef struct packed {
        halving_data_t val;
        halving_data_t div2;
        halving_data_t div4;
        logic          mismatch2;
        logic          mismatch4;
    } halving_word_t;

    // Unsigned halving: plain right shift, no rounding.
    function automatic halving_data_t halve(input halving_data_t x);
        return x >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/halving_stage.sv
`default_nettype none
// ============================================================================
//  Module      : halving_stage
//  Description : One valid/ready register slice carrying a halving_word_t.
//                Accepts whenever empty or when the held word is leaving.
//  Revision    : 1.0 - initial release
// ============================================================================
module halving_stage
    import halving_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  halving_word_t in_word,
    output logic          out_valid,
    input  logic          out_ready,
    output halving_word_t out_word
);

    logic          valid_q;
    logic          valid_d;
    halving_word_t word_q;
    halving_word_t word_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_word  = word_q;

    // Next-state: load on an accepted word, otherwise hold; valid tracks
    // whatever is offered whenever the slot is free to change.
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        if (in_ready) begin
            valid_d = in_valid;
        end
        if (in_ready && in_valid) begin
            word_d = in_word;
        end
    end

    // Valid bit: cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data payload: no reset, it is qualified by valid_q.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

endmodule
`default_nettype wire

// File: rtl/halving_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : halving_pipe
//  Description : Two-stage valid/ready pipeline producing val/2, val/4 and
//                inexactness flags, plus a saturating count and sticky flag
//                of inexact-quarter results seen at the output.
//                WIDTH may range from 3 up to halving_pkg::HALVING_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module halving_pipe
    import halving_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic [WIDTH-1:0] out_div2,
    output logic [WIDTH-1:0] out_div4,
    output logic             out_mismatch2,
    output logic             out_mismatch4,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky
);

    halving_data_t val_ext;
    halving_word_t s1_in;
    halving_word_t s1_out;
    halving_word_t s2_in;
    halving_word_t s2_out;
    logic          s1_valid;
    logic          s2_ready;
    logic          count_hs;

    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] err_count_d;
    logic             err_sticky_q;
    logic             err_sticky_d;

    // Stage-1 payload: value, its half and the odd flag.
    always_comb begin
        val_ext              = '0;
        val_ext[WIDTH-1:0]   = in_data;
        s1_in                = '0;
        s1_in.val            = val_ext;
        s1_in.div2           = halve(val_ext);
        s1_in.mismatch2      = val_ext[0];
    end

    halving_stage u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_word  (s1_out)
    );

    // Stage-2 payload: quarter chained from the registered half; the
    // quarter is inexact if either of the two low value bits was set.
    always_comb begin
        s2_in           = s1_out;
        s2_in.div4      = halve(s1_out.div2);
        s2_in.mismatch4 = s1_out.mismatch2 | s1_out.div2[0];
    end

    halving_stage u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_word   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (s2_out)
    );

    assign out_val       = s2_out.val[WIDTH-1:0];
    assign out_div2      = s2_out.div2[WIDTH-1:0];
    assign out_div4      = s2_out.div4[WIDTH-1:0];
    assign out_mismatch2 = s2_out.mismatch2;
    assign out_mismatch4 = s2_out.mismatch4;

    assign count_hs = out_valid && out_ready && out_mismatch4;

    // Error bookkeeping: clear has priority over a counting handshake.
    always_comb begin
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        if (clear) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end else if (count_hs) begin
            err_sticky_d = 1'b1;
            if (err_count_q != {CNT_W{1'b1}}) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    // Error counter and sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_count  = err_count_q;
    assign err_sticky = err_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_halving_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_halving_pipe
//  Description : Self-checking bench for halving_pipe: directed scenarios plus
//                a randomized stream compared against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_halving_pipe;

    localparam int WIDTH   = 32;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_val;
    logic [WIDTH-1:0] out_div2;
    logic [WIDTH-1:0] out_div4;
    logic             out_mismatch2;
    logic             out_mismatch4;
    logic [CNT_W-1:0] err_count;
    logic             err_sticky;

    halving_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_val       (out_val),
        .out_div2      (out_div2),
        .out_div4      (out_div4),
        .out_mismatch2 (out_mismatch2),
        .out_mismatch4 (out_mismatch4),
        .err_count     (err_count),
        .err_sticky    (err_sticky)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: words in flight with the cycle they were offered.
    logic [WIDTH-1:0] q_val[$];
    int               q_t[$];
    int               m_cnt    = 0;
    bit               m_sticky = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks every cycle at the falling edge, then advances the model.
    always @(negedge clk) begin
        logic             exp_ov;
        logic             exp_ir;
        logic [WIDTH-1:0] v;
        if (!rst) begin
            exp_ov = (q_val.size() > 0) && (q_t[0] + 2 <= cyc);
            exp_ir = (q_val.size() < 2) || out_ready;
            v      = (q_val.size() > 0) ? q_val[0] : '0;
            check("in_ready", in_ready, exp_ir);
            check("out_valid", out_valid, exp_ov);
            if (exp_ov && out_valid) begin
                check("out_val", out_val, v);
                check("out_div2", out_div2, v / 2);
                check("out_div4", out_div4, v / 4);
                check("out_mismatch2", out_mismatch2, (v % 2) != 0);
                check("out_mismatch4", out_mismatch4, (v % 4) != 0);
            end
            check("err_count", err_count, m_cnt);
            check("err_sticky", err_sticky, m_sticky);
            if (clear) begin
                m_cnt    = 0;
                m_sticky = 1'b0;
            end else if (exp_ov && out_ready && (v % 4) != 0) begin
                if (m_cnt < CNT_MAX) m_cnt++;
                m_sticky = 1'b1;
            end
            if (exp_ov && out_ready) begin
                void'(q_val.pop_front());
                void'(q_t.pop_front());
            end
            if (in_valid && exp_ir) begin
                q_val.push_back(in_data);
                q_t.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] v);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 50 && !acc; i++) begin
            #1;
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic wait_out_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else step();
        end
        if (!seen) check("out_valid_timeout", 0, 1);
    endtask

    initial begin
        int k;
        int accepted;
        logic [WIDTH-1:0] w[4];

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err_count", err_count, 0);
        check("rst_err_sticky", err_sticky, 0);
        step();

        // Single word, unstalled: visible two edges after being offered
        send(28);
        step();
        check("w28_valid", out_valid, 1);
        check("w28_div2", out_div2, 14);
        check("w28_div4", out_div4, 7);
        check("w28_m2", out_mismatch2, 0);
        check("w28_m4", out_mismatch4, 0);
        step();
        check("w28_err_count", err_count, 0);

        // Back-to-back stream
        in_valid = 1'b1;
        in_data = 68; step();
        in_data = 30; step();
        in_data = 5;  step();
        in_valid = 1'b0;
        repeat (4) step();
        check("stream_err_count", err_count, 2);
        check("stream_err_sticky", err_sticky, 1);
        clear = 1'b1; step(); clear = 1'b0; step();
        check("clear_err_count", err_count, 0);

        // Stall: only two words fit while out_ready is low
        w[0] = 40; w[1] = 41; w[2] = 42; w[3] = 43;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = w[k];
            #1;
            if (in_ready) k++;
            step();
        end
        check("stall_accepts", k, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_hold_val", out_val, 40);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && k < 4; i++) begin
            in_data = w[k];
            #1;
            if (in_ready) k++;
            step();
        end
        in_valid = 1'b0;
        check("stall_all_accepted", k, 4);
        repeat (4) step();

        // Saturation then clear colliding with a counting handshake
        for (int i = 0; i < 5; i++) send(1);
        repeat (4) step();
        check("sat_err_count", err_count, CNT_MAX);
        check("sat_err_sticky", err_sticky, 1);
        out_ready = 1'b0;
        send(1);
        wait_out_valid();
        out_ready = 1'b1;
        clear     = 1'b1;
        step();
        clear = 1'b0;
        check("clr_win_count", err_count, 0);
        check("clr_win_sticky", err_sticky, 0);
        step();

        // Reset with both stages full
        out_ready = 1'b0;
        send(100);
        send(101);
        step();
        check("full_in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        q_val.delete();
        q_t.delete();
        m_cnt = 0;
        m_sticky = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        out_ready = 1'b1;
        step();
        send(12);
        step();
        check("w12_valid", out_valid, 1);
        check("w12_val", out_val, 12);
        check("w12_div2", out_div2, 6);
        check("w12_div4", out_div4, 3);
        check("w12_m2", out_mismatch2, 0);
        check("w12_m4", out_mismatch4, 0);
        step();

        // Randomized stream against the model
        accepted = 0;
        for (int i = 0; i < 60000 && accepted < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            if ($urandom_range(0, 3) == 0) in_data = WIDTH'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 63) == 0);
            #1;
            if (in_valid && in_ready) accepted++;
            step();
        end
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        check("random_accepted", accepted, 10000);
        repeat (5) step();
        check("drain_empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
